// File: rtl/cr16_alu_arbiter.sv
// cr16_alu_arbiter: two-port valid/ready front end sharing one registered cr16_alu.
// Define CR16_ALU_ARB_RR_EN for round-robin contention handling; otherwise port 0 has fixed priority.
module cr16_alu_arbiter #(
    parameter int P_WIDTH = 16
) (
    input  logic               I_CLK,
    input  logic               I_NRESET,

    input  logic               I_REQ0_VALID,
    output logic               O_REQ0_READY,
    input  logic [3:0]         I_REQ0_OPCODE,
    input  logic [P_WIDTH-1:0] I_REQ0_A,
    input  logic [P_WIDTH-1:0] I_REQ0_B,

    input  logic               I_REQ1_VALID,
    output logic               O_REQ1_READY,
    input  logic [3:0]         I_REQ1_OPCODE,
    input  logic [P_WIDTH-1:0] I_REQ1_A,
    input  logic [P_WIDTH-1:0] I_REQ1_B,

    output logic               O_RSP0_VALID,
    output logic [P_WIDTH-1:0] O_RSP0_C,
    output logic [4:0]         O_RSP0_STATUS,
    output logic               O_RSP0_ERR,

    output logic               O_RSP1_VALID,
    output logic [P_WIDTH-1:0] O_RSP1_C,
    output logic [4:0]         O_RSP1_STATUS,
    output logic               O_RSP1_ERR,

    output logic               O_ALU_ENABLE,
    output logic [3:0]         O_ALU_OPCODE,
    output logic [P_WIDTH-1:0] O_ALU_A,
    output logic [P_WIDTH-1:0] O_ALU_B,
    input  logic [P_WIDTH-1:0] I_ALU_C,
    input  logic [4:0]         I_ALU_STATUS
);

    logic       grant0;
    logic       grant1;
    logic       anyGrant;
    logic       illegal;
    logic [3:0] selOpcode;

    logic last_q, last_d;
    logic tagValid_q, tagValid_d;
    logic tagPort_q, tagPort_d;
    logic tagErr_q, tagErr_d;

    logic rsp0Live;
    logic rsp1Live;

    // last_q == 1 after reset, so port 0 wins the first contention in either mode.
    always_comb begin
`ifdef CR16_ALU_ARB_RR_EN
        grant0 = I_REQ0_VALID & (~I_REQ1_VALID | last_q);
`else
        grant0 = I_REQ0_VALID;
`endif
        grant1 = I_REQ1_VALID & ~grant0;
    end

    assign anyGrant     = grant0 | grant1;
    assign selOpcode    = grant1 ? I_REQ1_OPCODE : I_REQ0_OPCODE;
    assign illegal      = &selOpcode[3:1];

    assign O_REQ0_READY = grant0;
    assign O_REQ1_READY = grant1;
    assign O_ALU_ENABLE = anyGrant & ~illegal;
    assign O_ALU_OPCODE = selOpcode;
    assign O_ALU_A      = grant1 ? I_REQ1_A : I_REQ0_A;
    assign O_ALU_B      = grant1 ? I_REQ1_B : I_REQ0_B;

    always_comb begin
        tagValid_d = anyGrant;
        tagPort_d  = grant1;
        tagErr_d   = anyGrant & illegal;
        last_d     = anyGrant ? grant1 : last_q;
    end

    always_ff @(posedge I_CLK) begin
        if (!I_NRESET) begin
            tagValid_q <= 1'b0;
            tagPort_q  <= 1'b0;
            tagErr_q   <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            tagValid_q <= tagValid_d;
            tagPort_q  <= tagPort_d;
            tagErr_q   <= tagErr_d;
            last_q     <= last_d;
        end
    end

    // ALU outputs are never reset, so everything returned is masked by the tag.
    assign rsp0Live      = tagValid_q & ~tagPort_q;
    assign rsp1Live      = tagValid_q & tagPort_q;

    assign O_RSP0_VALID  = rsp0Live;
    assign O_RSP0_ERR    = rsp0Live & tagErr_q;
    assign O_RSP0_C      = (rsp0Live & ~tagErr_q) ? I_ALU_C : '0;
    assign O_RSP0_STATUS = (rsp0Live & ~tagErr_q) ? I_ALU_STATUS : '0;

    assign O_RSP1_VALID  = rsp1Live;
    assign O_RSP1_ERR    = rsp1Live & tagErr_q;
    assign O_RSP1_C      = (rsp1Live & ~tagErr_q) ? I_ALU_C : '0;
    assign O_RSP1_STATUS = (rsp1Live & ~tagErr_q) ? I_ALU_STATUS : '0;

endmodule

// File: tb/tb_cr16_alu_arbiter.sv
// Bench for cr16_alu_arbiter: registered ALU stub, directed literal checks and a randomized reference model.
// Honours CR16_ALU_ARB_RR_EN the same way the design does.
module tb_cr16_alu_arbiter;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          nreset;
    logic          v0, v1;
    logic [3:0]    op0, op1;
    logic [W-1:0]  a0, b0, a1, b1;

    logic          rdy0, rdy1;
    logic          rsp0V, rsp1V, rsp0E, rsp1E;
    logic [W-1:0]  rsp0C, rsp1C;
    logic [4:0]    rsp0S, rsp1S;
    logic          aluEn;
    logic [3:0]    aluOp;
    logic [W-1:0]  aluA, aluB;
    logic [W-1:0]  aluC = '0;
    logic [4:0]    aluS = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cr16_alu_arbiter #(.P_WIDTH(W)) dut (
        .I_CLK(clk), .I_NRESET(nreset),
        .I_REQ0_VALID(v0), .O_REQ0_READY(rdy0), .I_REQ0_OPCODE(op0), .I_REQ0_A(a0), .I_REQ0_B(b0),
        .I_REQ1_VALID(v1), .O_REQ1_READY(rdy1), .I_REQ1_OPCODE(op1), .I_REQ1_A(a1), .I_REQ1_B(b1),
        .O_RSP0_VALID(rsp0V), .O_RSP0_C(rsp0C), .O_RSP0_STATUS(rsp0S), .O_RSP0_ERR(rsp0E),
        .O_RSP1_VALID(rsp1V), .O_RSP1_C(rsp1C), .O_RSP1_STATUS(rsp1S), .O_RSP1_ERR(rsp1E),
        .O_ALU_ENABLE(aluEn), .O_ALU_OPCODE(aluOp), .O_ALU_A(aluA), .O_ALU_B(aluB),
        .I_ALU_C(aluC), .I_ALU_STATUS(aluS)
    );

    // Stand-in for the registered ALU: result {status, c} for a given operation.
    function automatic logic [20:0] aluRef(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [16:0]  s;
        logic [W-1:0] c;
        logic [4:0]   st;
        s  = '0;
        c  = '0;
        st = '0;
        case (op)
            4'd0: begin
                s  = {1'b0, a} + {1'b0, b};
                c  = s[15:0];
                st = {c[15], c == 16'h0, (a[15] == b[15]) && (c[15] != a[15]), 1'b0, 1'b0};
            end
            4'd1: begin
                s  = {1'b0, a} + {1'b0, b};
                c  = s[15:0];
                st = {1'b0, c == 16'h0, 1'b0, 1'b0, s[16]};
            end
            4'd2: begin
                c  = b - a;
                st = {1'b0, c == 16'h0, 1'b0, a > b, 1'b0};
            end
            4'd3: begin
                c  = a ^ b;
                st = {1'b0, c == 16'h0, 3'b000};
            end
            default: begin
                c  = (a << 1) ^ b ^ {12'h0, op};
                st = {c[15], c == 16'h0, 1'b0, c[0], op[0]};
            end
        endcase
        return {st, c};
    endfunction

    always @(posedge clk) begin
        if (aluEn) {aluS, aluC} <= aluRef(aluOp, aluA, aluB);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending response slot plus the most-recently-granted pointer.
    bit           mdlReady = 0;
    bit           lastM;
    bit           pendV, pendPort, pendErr;
    logic [W-1:0] pendC;
    logic [4:0]   pendS;
    bit           expG0, expG1;

    always @(negedge clk) begin
        bit           ill;
        bit           expEn;
        logic [3:0]   selOp;
        logic [W-1:0] eC0, eC1;
        logic [4:0]   eS0, eS1;
        if (mdlReady) begin
`ifdef CR16_ALU_ARB_RR_EN
            expG0 = v0 && (!v1 || lastM);
`else
            expG0 = v0;
`endif
            expG1 = v1 && !expG0;
            selOp = expG1 ? op1 : op0;
            ill   = (selOp >= 4'd14);
            expEn = (expG0 || expG1) && !ill;
            checkOutput("ready0", rdy0, expG0);
            checkOutput("ready1", rdy1, expG1);
            checkOutput("alu_enable", aluEn, expEn);
            if (expEn) begin
                checkOutput("alu_opcode", aluOp, selOp);
                checkOutput("alu_a", aluA, expG1 ? a1 : a0);
                checkOutput("alu_b", aluB, expG1 ? b1 : b0);
            end
            eC0 = (pendV && !pendPort && !pendErr) ? pendC : '0;
            eS0 = (pendV && !pendPort && !pendErr) ? pendS : '0;
            eC1 = (pendV && pendPort && !pendErr) ? pendC : '0;
            eS1 = (pendV && pendPort && !pendErr) ? pendS : '0;
            checkOutput("rsp0_valid", rsp0V, pendV && !pendPort);
            checkOutput("rsp0_err", rsp0E, pendV && !pendPort && pendErr);
            checkOutput("rsp0_c", rsp0C, eC0);
            checkOutput("rsp0_status", rsp0S, eS0);
            checkOutput("rsp1_valid", rsp1V, pendV && pendPort);
            checkOutput("rsp1_err", rsp1E, pendV && pendPort && pendErr);
            checkOutput("rsp1_c", rsp1C, eC1);
            checkOutput("rsp1_status", rsp1S, eS1);
        end
    end

    always @(posedge clk) begin
        logic [3:0] gop;
        if (nreset === 1'b0) begin
            pendV    = 0;
            pendErr  = 0;
            pendPort = 0;
            lastM    = 1;
            mdlReady = 1;
        end else if (mdlReady) begin
            pendV = expG0 || expG1;
            if (pendV) begin
                pendPort = expG1;
                gop      = expG1 ? op1 : op0;
                pendErr  = (gop >= 4'd14);
                {pendS, pendC} = expG1 ? aluRef(op1, a1, b1) : aluRef(op0, a0, b0);
                lastM    = expG1;
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit p, input bit v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (p) begin
            v1 = v; op1 = op; a1 = a; b1 = b;
        end else begin
            v0 = v; op0 = op; a0 = a; b0 = b;
        end
    endtask

    task automatic doReset();
        nextCycle();
        nreset = 0;
        v0 = 0;
        v1 = 0;
        nextCycle();
        nreset = 1;
    endtask

    bit exp0[4];

    initial begin
        nreset = 0;
        v0 = 0; v1 = 0;
        op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        nextCycle();
        nextCycle();
        nreset = 1;

        $display("[TB] reset state");
        @(negedge clk);
        checkOutput("reset_rsp0_valid", rsp0V, 0);
        checkOutput("reset_rsp1_valid", rsp1V, 0);

        $display("[TB] single ADD");
        doReset();
        applyStimulus(0, 1, 4'd0, 16'h0003, 16'h0004);
        @(negedge clk);
        checkOutput("add_ready0", rdy0, 1);
        checkOutput("add_ready1", rdy1, 0);
        checkOutput("add_enable", aluEn, 1);
        nextCycle();
        v0 = 0;
        @(negedge clk);
        checkOutput("add_rsp0_valid", rsp0V, 1);
        checkOutput("add_rsp0_c", rsp0C, 16'h0007);
        checkOutput("add_rsp0_status", rsp0S, 5'b00000);
        checkOutput("add_rsp0_err", rsp0E, 0);
        checkOutput("add_rsp1_valid", rsp1V, 0);

        $display("[TB] contention");
`ifdef CR16_ALU_ARB_RR_EN
        exp0 = '{1, 0, 1, 0};
`else
        exp0 = '{1, 1, 1, 1};
`endif
        doReset();
        applyStimulus(0, 1, 4'd1, 16'hFFFF, 16'h0001);
        applyStimulus(1, 1, 4'd1, 16'hFFFF, 16'h0001);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("cont_ready0", rdy0, exp0[k]);
            checkOutput("cont_ready1", rdy1, !exp0[k]);
            if (k > 0) begin
                checkOutput("cont_rsp_valid", exp0[k-1] ? rsp0V : rsp1V, 1);
                checkOutput("cont_rsp_c", exp0[k-1] ? rsp0C : rsp1C, 16'h0000);
                checkOutput("cont_rsp_status", exp0[k-1] ? rsp0S : rsp1S, 5'b01001);
            end
            nextCycle();
        end
        v0 = 0;
        @(negedge clk);
        checkOutput("cont_drop_ready1", rdy1, 1);
        checkOutput("cont_last_rsp_status", exp0[3] ? rsp0S : rsp1S, 5'b01001);
        nextCycle();
        v1 = 0;

        $display("[TB] illegal opcode");
        nextCycle();
        applyStimulus(1, 1, 4'd15, 16'h1234, 16'h5678);
        @(negedge clk);
        checkOutput("ill_ready1", rdy1, 1);
        checkOutput("ill_enable", aluEn, 0);
        nextCycle();
        v1 = 0;
        @(negedge clk);
        checkOutput("ill_rsp1_valid", rsp1V, 1);
        checkOutput("ill_rsp1_err", rsp1E, 1);
        checkOutput("ill_rsp1_c", rsp1C, 16'h0000);
        checkOutput("ill_rsp1_status", rsp1S, 5'b00000);

        $display("[TB] back-to-back");
        nextCycle();
        applyStimulus(0, 1, 4'd2, 16'h0005, 16'h0003);
        nextCycle();
        v0 = 0;
        applyStimulus(1, 1, 4'd3, 16'h00FF, 16'h00FF);
        @(negedge clk);
        checkOutput("b2b_rsp0_valid", rsp0V, 1);
        checkOutput("b2b_rsp0_c", rsp0C, 16'hFFFE);
        checkOutput("b2b_rsp0_status", rsp0S, 5'b00010);
        checkOutput("b2b_ready1", rdy1, 1);
        nextCycle();
        v1 = 0;
        @(negedge clk);
        checkOutput("b2b_rsp1_valid", rsp1V, 1);
        checkOutput("b2b_rsp1_c", rsp1C, 16'h0000);
        checkOutput("b2b_rsp1_status", rsp1S, 5'b01000);

        $display("[TB] reset mid-flight");
        nextCycle();
        applyStimulus(0, 1, 4'd0, 16'h0001, 16'h0001);
        nreset = 0;
        @(negedge clk);
        checkOutput("mid_ready0", rdy0, 1);
        nextCycle();
        nreset = 1;
        v0 = 0;
        @(negedge clk);
        checkOutput("mid_rsp0_valid", rsp0V, 0);
        checkOutput("mid_rsp1_valid", rsp1V, 0);
        nextCycle();
        v0 = 1;
        v1 = 1;
        @(negedge clk);
        checkOutput("mid_first_ready0", rdy0, 1);
        checkOutput("mid_first_ready1", rdy1, 0);
        nextCycle();
        v0 = 0;
        v1 = 0;

        $display("[TB] randomized traffic");
        for (int n = 0; n < 1500; n++) begin
            bit hold0, hold1;
            hold0 = v0 && !expG0;
            hold1 = v1 && !expG1;
            nextCycle();
            nreset = ($urandom_range(0, 99) != 0);
            if (!hold0)
                applyStimulus(0, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                              16'($urandom), 16'($urandom));
            if (!hold1)
                applyStimulus(1, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
                              16'($urandom), 16'($urandom));
        end
        nextCycle();
        nreset = 1;
        v0 = 0;
        v1 = 0;
        nextCycle();
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
